// File: rtl/rob_pkg.sv
// Shared types and encodings for the reorder buffer.
// Optional performance counters are enabled by defining ROB_PERF_CNT_EN.
package rob_pkg;

    localparam int ROB_SIZE_WIDTH_DEF = 3;

    typedef enum logic [1:0] {
        ROB_TYPE_REG  = 2'd0,
        ROB_TYPE_BR   = 2'd1,
        ROB_TYPE_ST   = 2'd2,
        ROB_TYPE_EXIT = 2'd3
    } rob_type_e;

    typedef struct packed {
        logic        busy;
        logic        ready;
        rob_type_e   rtype;
        logic [4:0]  rd;
        logic [31:0] value;
        logic [31:0] pc;
        logic [31:0] pred_pc;
        logic [31:0] next_pc;
    } rob_entry_t;

    function automatic logic is_mispredict(input rob_entry_t e);
        return (e.rtype == ROB_TYPE_BR) && (e.next_pc != e.pred_pc);
    endfunction

endpackage

// File: rtl/rob_if.sv
// Issue, writeback, lookup and commit signals of the reorder buffer.
// The master side is the core around the ROB; the slave side is the ROB itself.
interface rob_if #(
    parameter int W = 3
);
    logic          issue_valid;
    logic [1:0]    issue_type;
    logic [4:0]    issue_rd;
    logic [31:0]   issue_pc;
    logic [31:0]   issue_pred_pc;
    logic          issue_ready;
    logic [31:0]   issue_value;
    logic [W-1:0]  issue_rob_id;
    logic          rob_full;
    logic          alu_valid;
    logic [W-1:0]  alu_rob_id;
    logic [31:0]   alu_value;
    logic [31:0]   alu_next_pc;
    logic          lsb_valid;
    logic [W-1:0]  lsb_rob_id;
    logic [31:0]   lsb_value;
    logic [W-1:0]  ask_rob_id1;
    logic [W-1:0]  ask_rob_id2;
    logic [31:0]   get_value1;
    logic [31:0]   get_value2;
    logic          get_ready1;
    logic          get_ready2;
    logic [W-1:0]  commit_rob_id;
    logic [4:0]    commit_rd;
    logic [31:0]   commit_value;
    logic          store_commit;
    logic [W-1:0]  store_commit_rob_id;
    logic [W-1:0]  head_rob_id;
    logic          rob_clear;
    logic [31:0]   back_pc;
    logic          halt;

    modport slave (
        input  issue_valid, issue_type, issue_rd, issue_pc, issue_pred_pc, issue_ready, issue_value,
        input  alu_valid, alu_rob_id, alu_value, alu_next_pc,
        input  lsb_valid, lsb_rob_id, lsb_value,
        input  ask_rob_id1, ask_rob_id2,
        output issue_rob_id, rob_full, get_value1, get_value2, get_ready1, get_ready2,
        output commit_rob_id, commit_rd, commit_value, store_commit, store_commit_rob_id,
        output head_rob_id, rob_clear, back_pc, halt
    );

    modport master (
        output issue_valid, issue_type, issue_rd, issue_pc, issue_pred_pc, issue_ready, issue_value,
        output alu_valid, alu_rob_id, alu_value, alu_next_pc,
        output lsb_valid, lsb_rob_id, lsb_value,
        output ask_rob_id1, ask_rob_id2,
        input  issue_rob_id, rob_full, get_value1, get_value2, get_ready1, get_ready2,
        input  commit_rob_id, commit_rd, commit_value, store_commit, store_commit_rob_id,
        input  head_rob_id, rob_clear, back_pc, halt
    );
endinterface

// File: rtl/rob_query.sv
// Operand lookup for the decoder: a writeback landing this cycle wins over the stored entry.
module rob_query
    import rob_pkg::*;
#(
    parameter int W = 3
) (
    input  logic [W-1:0] ask_id_i,
    input  logic         alu_valid_i,
    input  logic [W-1:0] alu_id_i,
    input  logic [31:0]  alu_value_i,
    input  logic         lsb_valid_i,
    input  logic [W-1:0] lsb_id_i,
    input  logic [31:0]  lsb_value_i,
    input  logic         stored_ready_i,
    input  logic [31:0]  stored_value_i,
    output logic         get_ready_o,
    output logic [31:0]  get_value_o
);
    // Bypass selection, ALU before LSB before stored contents
    always_comb begin
        get_ready_o = stored_ready_i;
        get_value_o = stored_value_i;
        if (alu_valid_i && (alu_id_i == ask_id_i)) begin
            get_ready_o = 1'b1;
            get_value_o = alu_value_i;
        end else if (lsb_valid_i && (lsb_id_i == ask_id_i)) begin
            get_ready_o = 1'b1;
            get_value_o = lsb_value_i;
        end else begin
            get_ready_o = stored_ready_i;
            get_value_o = stored_value_i;
        end
    end
endmodule

// File: rtl/rob.sv
// Reorder buffer: in-order allocate, out-of-order writeback, in-order commit with flush.
// Define ROB_PERF_CNT_EN to add the perf_commit_cnt / perf_flush_cnt counters.
module rob
    import rob_pkg::*;
#(
    parameter int ROB_SIZE_WIDTH = ROB_SIZE_WIDTH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
`ifdef ROB_PERF_CNT_EN
    output logic [31:0] perf_commit_cnt,
    output logic [31:0] perf_flush_cnt,
`endif
    rob_if.slave        bus
);
    localparam int W     = ROB_SIZE_WIDTH;
    localparam int DEPTH = 1 << W;
    localparam logic [W:0] FULL_CNT = (W+1)'(DEPTH);

    rob_entry_t ent_q [DEPTH];
    rob_entry_t ent_d [DEPTH];
    logic [W-1:0] head_q, head_d, tail_q, tail_d;
    logic [W:0]   cnt_q, cnt_d;
    logic [W-1:0] commit_rob_id_q, commit_rob_id_d, store_commit_rob_id_q, store_commit_rob_id_d;
    logic [4:0]   commit_rd_q, commit_rd_d;
    logic [31:0]  commit_value_q, commit_value_d, back_pc_q, back_pc_d;
    logic         store_commit_q, store_commit_d, rob_clear_q, rob_clear_d, halt_q, halt_d;

    rob_entry_t       head_ent_s;
    logic             full_s, do_commit_s, do_flush_s, do_issue_s;
    logic [DEPTH-1:0] alu_hit_s, lsb_hit_s;

    // Commit, flush and issue decisions from registered state
    always_comb begin
        head_ent_s  = ent_q[head_q];
        full_s      = (cnt_q == FULL_CNT);
        do_commit_s = rdy && head_ent_s.busy && head_ent_s.ready;
        do_flush_s  = do_commit_s && is_mispredict(head_ent_s);
        do_issue_s  = rdy && bus.issue_valid && !full_s && !do_flush_s;
    end

    // Writeback hits only count against entries that are still in flight
    always_comb begin
        alu_hit_s = '0;
        lsb_hit_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            alu_hit_s[i] = bus.alu_valid && (bus.alu_rob_id == W'(i)) && ent_q[i].busy;
            lsb_hit_s[i] = bus.lsb_valid && (bus.lsb_rob_id == W'(i)) && ent_q[i].busy;
        end
    end

    // Per-entry next state
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            if (!rdy) begin
                ent_d[i] = ent_q[i];
            end else if (do_flush_s) begin
                ent_d[i].busy  = 1'b0;
                ent_d[i].ready = 1'b0;
            end else if (do_issue_s && (tail_q == W'(i))) begin
                ent_d[i] = '{busy: 1'b1, ready: bus.issue_ready, rtype: rob_type_e'(bus.issue_type),
                             rd: bus.issue_rd, value: bus.issue_value, pc: bus.issue_pc,
                             pred_pc: bus.issue_pred_pc, next_pc: 32'd0};
            end else if (do_commit_s && (head_q == W'(i))) begin
                ent_d[i].busy  = 1'b0;
                ent_d[i].ready = 1'b0;
            end else begin
                ent_d[i].ready   = ent_q[i].ready | alu_hit_s[i] | lsb_hit_s[i];
                ent_d[i].value   = alu_hit_s[i] ? bus.alu_value :
                                   (lsb_hit_s[i] ? bus.lsb_value : ent_q[i].value);
                ent_d[i].next_pc = alu_hit_s[i] ? bus.alu_next_pc : ent_q[i].next_pc;
            end
        end
    end

    // Pointers, occupancy and commit outputs; pulses clear on every active cycle
    always_comb begin
        head_d                = head_q;
        tail_d                = tail_q;
        cnt_d                 = cnt_q;
        commit_rob_id_d       = commit_rob_id_q;
        commit_rd_d           = commit_rd_q;
        commit_value_d        = commit_value_q;
        store_commit_d        = store_commit_q;
        store_commit_rob_id_d = store_commit_rob_id_q;
        rob_clear_d           = rob_clear_q;
        back_pc_d             = back_pc_q;
        halt_d                = halt_q;
        if (rdy) begin
            commit_rd_d    = 5'd0;
            store_commit_d = 1'b0;
            rob_clear_d    = 1'b0;
            head_d = do_commit_s ? head_q + W'(1) : head_q;
            tail_d = do_issue_s ? tail_q + W'(1) : tail_q;
            cnt_d  = cnt_q + {{W{1'b0}}, do_issue_s} - {{W{1'b0}}, do_commit_s};
            if (do_commit_s) begin
                case (head_ent_s.rtype)
                    ROB_TYPE_REG, ROB_TYPE_BR: begin
                        commit_rd_d     = head_ent_s.rd;
                        commit_value_d  = head_ent_s.value;
                        commit_rob_id_d = head_q;
                    end
                    ROB_TYPE_ST: begin
                        store_commit_d        = 1'b1;
                        store_commit_rob_id_d = head_q;
                    end
                    ROB_TYPE_EXIT: halt_d = 1'b1;
                    default:       halt_d = halt_q;
                endcase
            end else begin
                halt_d = halt_q;
            end
            if (do_flush_s) begin
                rob_clear_d = 1'b1;
                back_pc_d   = head_ent_s.next_pc;
                head_d      = '0;
                tail_d      = '0;
                cnt_d       = '0;
            end else begin
                back_pc_d = back_pc_q;
            end
        end else begin
            halt_d = halt_q;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            head_q                <= '0;
            tail_q                <= '0;
            cnt_q                 <= '0;
            commit_rob_id_q       <= '0;
            commit_rd_q           <= 5'd0;
            commit_value_q        <= 32'd0;
            store_commit_q        <= 1'b0;
            store_commit_rob_id_q <= '0;
            rob_clear_q           <= 1'b0;
            back_pc_q             <= 32'd0;
            halt_q                <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
            head_q                <= head_d;
            tail_q                <= tail_d;
            cnt_q                 <= cnt_d;
            commit_rob_id_q       <= commit_rob_id_d;
            commit_rd_q           <= commit_rd_d;
            commit_value_q        <= commit_value_d;
            store_commit_q        <= store_commit_d;
            store_commit_rob_id_q <= store_commit_rob_id_d;
            rob_clear_q           <= rob_clear_d;
            back_pc_q             <= back_pc_d;
            halt_q                <= halt_d;
        end
    end

    rob_query #(.W(W)) u_query1 (
        .ask_id_i(bus.ask_rob_id1), .alu_valid_i(bus.alu_valid), .alu_id_i(bus.alu_rob_id),
        .alu_value_i(bus.alu_value), .lsb_valid_i(bus.lsb_valid), .lsb_id_i(bus.lsb_rob_id),
        .lsb_value_i(bus.lsb_value), .stored_ready_i(ent_q[bus.ask_rob_id1].ready),
        .stored_value_i(ent_q[bus.ask_rob_id1].value),
        .get_ready_o(bus.get_ready1), .get_value_o(bus.get_value1)
    );

    rob_query #(.W(W)) u_query2 (
        .ask_id_i(bus.ask_rob_id2), .alu_valid_i(bus.alu_valid), .alu_id_i(bus.alu_rob_id),
        .alu_value_i(bus.alu_value), .lsb_valid_i(bus.lsb_valid), .lsb_id_i(bus.lsb_rob_id),
        .lsb_value_i(bus.lsb_value), .stored_ready_i(ent_q[bus.ask_rob_id2].ready),
        .stored_value_i(ent_q[bus.ask_rob_id2].value),
        .get_ready_o(bus.get_ready2), .get_value_o(bus.get_value2)
    );

    assign bus.issue_rob_id        = tail_q;
    assign bus.head_rob_id         = head_q;
    assign bus.rob_full            = full_s;
    assign bus.commit_rob_id       = commit_rob_id_q;
    assign bus.commit_rd           = commit_rd_q;
    assign bus.commit_value        = commit_value_q;
    assign bus.store_commit        = store_commit_q;
    assign bus.store_commit_rob_id = store_commit_rob_id_q;
    assign bus.rob_clear           = rob_clear_q;
    assign bus.back_pc             = back_pc_q;
    assign bus.halt                = halt_q;

`ifdef ROB_PERF_CNT_EN
    logic [31:0] perf_commit_q, perf_flush_q;

    // Event counters, frozen while rdy is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_commit_q <= 32'd0;
            perf_flush_q  <= 32'd0;
        end else if (rdy) begin
            perf_commit_q <= perf_commit_q + {31'd0, do_commit_s};
            perf_flush_q  <= perf_flush_q + {31'd0, do_flush_s};
        end else begin
            perf_commit_q <= perf_commit_q;
            perf_flush_q  <= perf_flush_q;
        end
    end

    assign perf_commit_cnt = perf_commit_q;
    assign perf_flush_cnt  = perf_flush_q;
`endif
endmodule

// File: tb/tb_rob.sv
// Bench for rob: directed scenarios plus randomized traffic against an in-order queue model.
module tb_rob;
    import rob_pkg::*;

    localparam int W     = 3;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b1;
    rob_if #(.W(W)) bus ();
`ifdef ROB_PERF_CNT_EN
    logic [31:0] perf_commit_cnt, perf_flush_cnt;
`endif

    rob #(.ROB_SIZE_WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .rdy(rdy),
`ifdef ROB_PERF_CNT_EN
        .perf_commit_cnt(perf_commit_cnt),
        .perf_flush_cnt(perf_flush_cnt),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    // reference model: entry table indexed by id, plus head and occupancy
    bit          m_busy [DEPTH];
    bit          m_ready[DEPTH];
    int          m_type [DEPTH];
    logic [4:0]  m_rd   [DEPTH];
    logic [31:0] m_val  [DEPTH];
    logic [31:0] m_pred [DEPTH];
    logic [31:0] m_next [DEPTH];
    int          m_head, m_count;
    logic [4:0]  e_rd;
    logic [31:0] e_val, e_back;
    int          e_cid, e_sid;
    bit          e_reg, e_store, e_clear, e_halt;
    int          p_commit, p_flush;

    int vectors = 0;
    int checks = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_busy[i] = 0; m_ready[i] = 0; m_type[i] = 0; m_rd[i] = 5'd0;
            m_val[i] = 32'd0; m_pred[i] = 32'd0; m_next[i] = 32'd0;
        end
        m_head = 0; m_count = 0;
        e_rd = 5'd0; e_val = 32'd0; e_back = 32'd0; e_cid = 0; e_sid = 0;
        e_reg = 0; e_store = 0; e_clear = 0; e_halt = 0;
        p_commit = 0; p_flush = 0;
    endtask

    task automatic model_step();
        int  h, t;
        bit  commit, flush, issue;
        logic [31:0] h_next;
        if (!rdy) return;
        h      = m_head;
        t      = (m_head + m_count) % DEPTH;
        commit = m_busy[h] && m_ready[h];
        flush  = commit && (m_type[h] == int'(ROB_TYPE_BR)) && (m_next[h] != m_pred[h]);
        issue  = bus.issue_valid && (m_count < DEPTH) && !flush;
        h_next = m_next[h];
        e_rd = 5'd0; e_reg = 0; e_store = 0; e_clear = 0;
        if (commit) begin
            if (m_type[h] == int'(ROB_TYPE_REG) || m_type[h] == int'(ROB_TYPE_BR)) begin
                e_rd = m_rd[h]; e_val = m_val[h]; e_cid = h; e_reg = 1;
            end else if (m_type[h] == int'(ROB_TYPE_ST)) begin
                e_store = 1; e_sid = h;
            end else begin
                e_halt = 1;
            end
            p_commit++;
        end
        if (bus.lsb_valid && m_busy[bus.lsb_rob_id]) begin
            m_ready[bus.lsb_rob_id] = 1; m_val[bus.lsb_rob_id] = bus.lsb_value;
        end
        if (bus.alu_valid && m_busy[bus.alu_rob_id]) begin
            m_ready[bus.alu_rob_id] = 1; m_val[bus.alu_rob_id] = bus.alu_value;
            m_next[bus.alu_rob_id] = bus.alu_next_pc;
        end
        if (commit) begin
            m_busy[h] = 0; m_ready[h] = 0; m_head = (h + 1) % DEPTH; m_count--;
        end
        if (issue) begin
            m_busy[t] = 1; m_ready[t] = bus.issue_ready; m_type[t] = int'(bus.issue_type);
            m_rd[t] = bus.issue_rd; m_val[t] = bus.issue_value; m_pred[t] = bus.issue_pred_pc;
            m_next[t] = 32'd0; m_count++;
        end
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin m_busy[i] = 0; m_ready[i] = 0; end
            m_head = 0; m_count = 0; e_clear = 1; e_back = h_next; p_flush++;
        end
    endtask

    task automatic lookup_exp(input int a, output bit r, output logic [31:0] v);
        if (bus.alu_valid && int'(bus.alu_rob_id) == a) begin r = 1; v = bus.alu_value; end
        else if (bus.lsb_valid && int'(bus.lsb_rob_id) == a) begin r = 1; v = bus.lsb_value; end
        else begin r = m_ready[a]; v = m_val[a]; end
    endtask

    task automatic check_comb();
        bit r; logic [31:0] v;
        chk("rob_full", bus.rob_full, 32'(m_count == DEPTH));
        chk("issue_rob_id", bus.issue_rob_id, 32'((m_head + m_count) % DEPTH));
        chk("head_rob_id", bus.head_rob_id, 32'(m_head));
        lookup_exp(int'(bus.ask_rob_id1), r, v);
        chk("get_ready1", bus.get_ready1, 32'(r));
        if (r) chk("get_value1", bus.get_value1, v);
        lookup_exp(int'(bus.ask_rob_id2), r, v);
        chk("get_ready2", bus.get_ready2, 32'(r));
        if (r) chk("get_value2", bus.get_value2, v);
    endtask

    task automatic check_regs();
        chk("commit_rd", bus.commit_rd, 32'(e_rd));
        chk("store_commit", bus.store_commit, 32'(e_store));
        chk("rob_clear", bus.rob_clear, 32'(e_clear));
        chk("halt", bus.halt, 32'(e_halt));
        if (e_reg) begin
            chk("commit_value", bus.commit_value, e_val);
            chk("commit_rob_id", bus.commit_rob_id, 32'(e_cid));
        end
        if (e_store) chk("store_commit_rob_id", bus.store_commit_rob_id, 32'(e_sid));
        if (e_clear) chk("back_pc", bus.back_pc, e_back);
`ifdef ROB_PERF_CNT_EN
        chk("perf_commit_cnt", perf_commit_cnt, 32'(p_commit));
        chk("perf_flush_cnt", perf_flush_cnt, 32'(p_flush));
`endif
    endtask

    task automatic idle();
        bus.issue_valid = 1'b0; bus.issue_type = 2'd0; bus.issue_rd = 5'd0; bus.issue_pc = 32'd0;
        bus.issue_pred_pc = 32'd0; bus.issue_ready = 1'b0; bus.issue_value = 32'd0;
        bus.alu_valid = 1'b0; bus.alu_rob_id = '0; bus.alu_value = 32'd0; bus.alu_next_pc = 32'd0;
        bus.lsb_valid = 1'b0; bus.lsb_rob_id = '0; bus.lsb_value = 32'd0;
        bus.ask_rob_id1 = '0; bus.ask_rob_id2 = '0;
    endtask

    task automatic issue(input int typ, input int rd, input bit rdy_i, input logic [31:0] val,
                         input logic [31:0] pred);
        bus.issue_valid = 1'b1; bus.issue_type = 2'(typ); bus.issue_rd = 5'(rd);
        bus.issue_pc = 32'h100; bus.issue_pred_pc = pred; bus.issue_ready = rdy_i;
        bus.issue_value = val;
    endtask

    // called at a negedge with inputs set; returns at the following negedge
    task automatic tick();
        #1 check_comb();
        @(posedge clk);
        if (rst) model_step();
        #1 check_regs();
        vectors++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        chk("rst_commit_rd", bus.commit_rd, 32'd0);
        chk("rst_rob_clear", bus.rob_clear, 32'd0);
        chk("rst_halt", bus.halt, 32'd0);
        chk("rst_back_pc", bus.back_pc, 32'd0);
        chk("rst_store_commit", bus.store_commit, 32'd0);
        chk("rst_rob_full", bus.rob_full, 32'd0);
        chk("rst_issue_rob_id", bus.issue_rob_id, 32'd0);
        chk("rst_head_rob_id", bus.head_rob_id, 32'd0);
        rst = 1'b1;
    endtask

    initial begin
        int pend[$];
        int free[$];
        int k, a;
        idle();
        @(negedge clk);
        do_reset();

        // basic REG commit
        issue(0, 5, 0, 32'd0, 32'd0);
        chk("t1_issue_id", bus.issue_rob_id, 32'd0);
        tick();
        idle(); bus.alu_valid = 1'b1; bus.alu_rob_id = 3'd0; bus.alu_value = 32'h1234;
        tick();
        chk("t1_no_early_commit", bus.commit_rd, 32'd0);
        idle(); tick();
        chk("t1_commit_rd", bus.commit_rd, 32'd5);
        chk("t1_commit_value", bus.commit_value, 32'h1234);
        chk("t1_commit_rob_id", bus.commit_rob_id, 32'd0);
        tick();
        chk("t1_commit_rd_idle", bus.commit_rd, 32'd0);

        // fill, full, wrap
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin issue(0, i + 1, 0, 32'd0, 32'd0); tick(); end
        chk("t2_full", bus.rob_full, 32'd1);
        issue(0, 9, 0, 32'd0, 32'd0); tick();
        chk("t2_full_issue_ignored", bus.issue_rob_id, 32'd0);
        idle(); bus.alu_valid = 1'b1; bus.alu_rob_id = 3'd0; bus.alu_value = 32'hA; tick();
        idle(); tick();
        chk("t2_not_full", bus.rob_full, 32'd0);
        chk("t2_wrap_id", bus.issue_rob_id, 32'd0);
        chk("t2_head", bus.head_rob_id, 32'd1);

        // mispredict flush with a simultaneous issue
        do_reset();
        issue(1, 1, 0, 32'd0, 32'h104); tick();
        idle(); bus.alu_valid = 1'b1; bus.alu_rob_id = 3'd0; bus.alu_value = 32'h104;
        bus.alu_next_pc = 32'h200; tick();
        issue(0, 2, 0, 32'd0, 32'd0); tick();
        chk("t3_rob_clear", bus.rob_clear, 32'd1);
        chk("t3_back_pc", bus.back_pc, 32'h200);
        chk("t3_issue_dropped", bus.issue_rob_id, 32'd0);
        chk("t3_head", bus.head_rob_id, 32'd0);
        idle(); tick();
        chk("t3_clear_pulse", bus.rob_clear, 32'd0);

        // lookup bypass
        do_reset();
        for (int i = 0; i < 3; i++) begin issue(0, i + 1, 0, 32'd0, 32'd0); tick(); end
        idle(); bus.lsb_valid = 1'b1; bus.lsb_rob_id = 3'd2; bus.lsb_value = 32'hDEAD;
        bus.ask_rob_id1 = 3'd2; bus.ask_rob_id2 = 3'd1;
        #1;
        chk("t4_get_ready1", bus.get_ready1, 32'd1);
        chk("t4_get_value1", bus.get_value1, 32'hDEAD);
        chk("t4_get_ready2", bus.get_ready2, 32'd0);
        tick();

        // store then exit
        do_reset();
        issue(2, 0, 1, 32'd0, 32'd0); tick();
        idle(); tick();
        chk("t5_store_commit", bus.store_commit, 32'd1);
        chk("t5_store_id", bus.store_commit_rob_id, 32'd0);
        issue(3, 0, 1, 32'd0, 32'd0); tick();
        idle(); tick();
        tick(); tick();
        chk("t5_halt_sticky", bus.halt, 32'd1);

        // rdy stall
        do_reset();
        issue(0, 7, 1, 32'h55, 32'd0); tick();
        idle(); rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin tick(); chk("t6_stall", bus.commit_rd, 32'd0); end
        rdy = 1'b1; tick();
        chk("t6_commit_rd", bus.commit_rd, 32'd7);
        chk("t6_commit_value", bus.commit_value, 32'h55);

        // randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 1000 == 999) do_reset();
            idle();
            rdy = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 2) != 0) begin
                k = $urandom_range(0, 99);
                k = (k < 70) ? 0 : (k < 85) ? 1 : (k < 97) ? 2 : 3;
                issue(k, $urandom_range(0, 31), (k != 1) && ($urandom_range(0, 3) == 0),
                      $urandom, $urandom);
            end
            pend.delete(); free.delete();
            for (int i = 0; i < DEPTH; i++) begin
                if (m_busy[i] && !m_ready[i]) pend.push_back(i);
                if (!m_busy[i]) free.push_back(i);
            end
            if (pend.size() > 0 && $urandom_range(0, 9) < 6) begin
                k = $urandom_range(0, pend.size() - 1);
                a = pend[k];
                pend.delete(k);
                bus.alu_valid = 1'b1; bus.alu_rob_id = 3'(a); bus.alu_value = $urandom;
                bus.alu_next_pc = ($urandom_range(0, 3) == 0) ? $urandom : m_pred[a];
            end else if (free.size() > 0 && $urandom_range(0, 19) == 0) begin
                bus.alu_valid = 1'b1; bus.alu_rob_id = 3'(free[$urandom_range(0, free.size() - 1)]);
                bus.alu_value = $urandom; bus.alu_next_pc = $urandom;
            end
            if (pend.size() > 0 && $urandom_range(0, 1) == 0) begin
                bus.lsb_valid = 1'b1;
                bus.lsb_rob_id = 3'(pend[$urandom_range(0, pend.size() - 1)]);
                bus.lsb_value = $urandom;
            end
            bus.ask_rob_id1 = 3'($urandom_range(0, DEPTH - 1));
            bus.ask_rob_id2 = 3'($urandom_range(0, DEPTH - 1));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
